multicycle_main_cu: RTL
=======================

Name: multicycle_main_cu

Overview:
- Main control FSM for the multicycle RV32I datapath. It produces the ALUOp/funct3/funct7 triple consumed by ALU_CU, plus every datapath strobe.
- It sequences fetch, decode, execute, memory and writeback, and handshakes with instruction/data memory.
- It sits between the instruction register and the datapath; ALU_CU is its direct downstream consumer.

Parameters:
- MEM_TIMEOUT, 255, max cycles to wait for mem_ready in any memory state before flagging bus_error (8-bit counter; range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- instr  in  32  current IR contents (valid from DECODE onward)
- mem_ready  in  1  memory completes the current read/write this cycle
- zero  in  1  ALU zero flag (rs1-rs2 result)
- ALUOp  out  2  00 add, 01 sub (branch compare), 10 decode funct fields, 11 unused
- funct3  out  3  funct field to ALU_CU
- funct7  out  7  funct field to ALU_CU, sanitized (see Behaviour)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address select: 0 PC, 1 ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 rs1
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- wb_sel  out  1  0 ALUOut, 1 memory data
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- bus_error  out  1  sticky until reset: memory timeout occurred
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: synchronous on rising clk with rst_n=0. State goes to FETCH, timeout counter to 0, bus_error to 0. All strobes, ALUOp, funct3, funct7 and illegal_instr are forced 0 while rst_n=0.
- Outputs are Moore: decoded from state (plus instr fields). Exception: the pc_write qualifier in BRANCH uses zero.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00. Stays while mem_ready=0. When mem_ready=1, ir_write=1 and pc_write=1 (PC+4) in that cycle, then DECODE.
  - DECODE: no strobes. Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - anything else -> FETCH, with illegal_instr pulsed this cycle.
  - EXEC_R: ALUOp=10, alu_src_a=1, alu_src_b=00, funct3=instr[14:12], funct7=instr[31:25]; next WB_ALU.
  - EXEC_I: ALUOp=10, alu_src_b=10, funct3=instr[14:12]. funct7 is instr[31:25] only when funct3=101 (SRLI/SRAI); otherwise 0000000, so immediate bits never select SUB. Next WB_ALU.
  - MEM_ADDR: ALUOp=00, alu_src_a=1, alu_src_b=10. Next MEM_RD for load, MEM_WR for store.
  - MEM_RD: mem_read=1, iord=1. Stays until mem_ready=1, then WB_MEM.
  - MEM_WR: mem_write=1, iord=1. Stays until mem_ready=1, then FETCH.
  - WB_ALU: reg_write=1, wb_sel=0; next FETCH.
  - WB_MEM: reg_write=1, wb_sel=1; next FETCH.
  - BRANCH: ALUOp=01, alu_src_a=1, alu_src_b=00, funct3=instr[14:12], pc_write=zero (BEQ only; other funct3 -> pc_write=0, no illegal flag). Next FETCH.
- funct3 and funct7 are 0 in every state not listed above.
- Latency with mem_ready always 1: R/I 4 cycles, LW 5, SW 4, BEQ 3. Each wait cycle adds one.
- Timeout:
  - Counter clears on entering FETCH, MEM_RD or MEM_WR, and increments each wait cycle.
  - When count reaches MEM_TIMEOUT with mem_ready still 0: bus_error sets, the request is dropped, and the FSM goes to FETCH.
  - mem_ready on the same cycle as the timeout wins: normal transition, no error.
- Reset mid-instruction aborts immediately; no partial writeback occurs.
- Undefined state encodings recover to FETCH.

Decomposition:
- Package cu_pkg holds:
  - state enum (4-bit)
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
  - ALUOp encodings ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b encodings.
- No sub-module is required. The timeout counter stays inline.

Test Plan:
- instr=0x002081B3 (add x3,x1,x2), mem_ready=1 -> states FETCH, DECODE, EXEC_R (ALUOp=10, funct3=000, funct7=0000000), WB_ALU (reg_write=1); 4 cycles.
- instr=0xFFF00093 (addi x1,x0,-1) -> EXEC_I with funct7=0000000 and alu_src_b=10. Then 0x4030D093 (srai x1,x1,3) -> funct3=101, funct7=0100000.
- instr=0x0000A283 (lw) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with wb_sel=1 and reg_write=1.
- instr=0x00208463 (beq) with zero=1 -> pc_write=1 in BRANCH with ALUOp=01. Repeat with zero=0 -> pc_write=0.
- instr=0x0000007F -> illegal_instr pulses 1 cycle in DECODE, next state FETCH, no reg_write.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error=1 after 4 wait cycles, FETCH re-entered. rst_n=0 for one cycle mid-EXEC_R -> FETCH, all strobes 0, bus_error cleared.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle RV32I main control unit.
// Holds the FSM state enum, the opcodes the FSM recognises, and the ALUOp
// and ALU operand-B select encodings driven towards the datapath and ALU_CU.
package cu_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SRCB_W   = 2;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SRCB_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_SRXI = 3'b101;

  // True for opcodes the FSM knows how to sequence.
  function automatic logic op_supported(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_main_cu.sv
// Main control FSM for the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, handshakes with memory
// through mem_ready, and produces ALUOp/funct3/funct7 for ALU_CU plus all
// datapath strobes. A per-request wait counter flags a sticky bus_error when
// memory fails to answer within MEM_TIMEOUT cycles.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instr             current IR contents
//   mem_ready, zero   memory handshake, ALU zero flag
//   ALUOp/funct3/funct7                       ALU_CU control
//   mem_read/mem_write/iord/ir_write/pc_write memory and PC/IR strobes
//   reg_write/alu_src_a/alu_src_b/wb_sel      register file and ALU muxes
//   illegal_instr, bus_error, state_o         status and debug
module multicycle_main_cu
  import cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  input  logic                zero,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [F3_W-1:0]     funct3,
  output logic [F7_W-1:0]     funct7,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [SRCB_W-1:0]   alu_src_b,
  output logic                wb_sel,
  output logic                illegal_instr,
  output logic                bus_error,
  output logic [STATE_W-1:0]  state_o
);

  localparam int unsigned CNT_W = 8;

  state_e              state;
  state_e              state_nxt;
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    wait_cnt_nxt;
  logic                mem_wait_c;
  logic                timeout_c;

  logic [OPCODE_W-1:0] opcode;
  logic [F3_W-1:0]     instr_f3;
  logic [F7_W-1:0]     instr_f7;
  logic                unused_instr_bits;

  assign opcode            = instr[6:0];
  assign instr_f3          = instr[14:12];
  assign instr_f7          = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign state_o           = state;

  // Next state, memory-wait detection and timeout.
  always_comb begin
    state_nxt    = state;
    mem_wait_c   = 1'b0;
    timeout_c    = 1'b0;
    wait_cnt_nxt = '0;
    case (state)
      ST_FETCH: begin
        if (mem_ready) state_nxt = ST_DECODE;
        else           mem_wait_c = 1'b1;
      end
      ST_DECODE: begin
        case (opcode)
          OP_R:               state_nxt = ST_EXEC_R;
          OP_I:               state_nxt = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = ST_MEM_ADDR;
          OP_BRANCH:          state_nxt = ST_BRANCH;
          default:            state_nxt = ST_FETCH;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_nxt = ST_WB_ALU;
      ST_MEM_ADDR: state_nxt = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready) state_nxt = ST_WB_MEM;
        else           mem_wait_c = 1'b1;
      end
      ST_MEM_WR: begin
        if (mem_ready) state_nxt = ST_FETCH;
        else           mem_wait_c = 1'b1;
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH: state_nxt = ST_FETCH;
      default: state_nxt = ST_FETCH;
    endcase

    // The wait that brings the count to MEM_TIMEOUT abandons the request.
    timeout_c = mem_wait_c && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    if (timeout_c) state_nxt = ST_FETCH;

    // Counter is zero in every non-waiting cycle, so each request starts at 0.
    if (mem_wait_c && !timeout_c) wait_cnt_nxt = wait_cnt + CNT_W'(1);
  end

  // State, wait counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_c) bus_error <= 1'b1;
    end
  end

  // Moore strobes from state and IR fields; held at 0 during reset.
  always_comb begin
    ALUOp         = ALUOP_ADD;
    funct3        = '0;
    funct7        = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    wb_sel        = 1'b0;
    illegal_instr = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: illegal_instr = !op_supported(opcode);
        ST_EXEC_R: begin
          ALUOp     = ALUOP_FUNCT;
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RS2;
          funct3    = instr_f3;
          funct7    = instr_f7;
        end
        ST_EXEC_I: begin
          ALUOp     = ALUOP_FUNCT;
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          funct3    = instr_f3;
          // Immediate bits only reach funct7 for shifts, so they never pick SUB.
          funct7    = (instr_f3 == F3_SRXI) ? instr_f7 : '0;
        end
        ST_MEM_ADDR: begin
          ALUOp     = ALUOP_ADD;
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        ST_WB_ALU: reg_write = 1'b1;
        ST_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = 1'b1;
        end
        ST_BRANCH: begin
          ALUOp     = ALUOP_SUB;
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RS2;
          funct3    = instr_f3;
          // Only BEQ is taken; other branch funct3 values fall through silently.
          pc_write  = zero && (instr_f3 == F3_BEQ);
        end
        default: ;
      endcase
    end
  end

endmodule
